// File: rtl/vita49_pkg.sv
// Shared types for the VITA-49 stream arbiter and related packet-path blocks.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package vita49_pkg;

    // Upper bound on arbitrated ports; sets the width of grant_id.
    localparam int MAX_ARB_PORTS = 8;
    localparam int GRANT_ID_W    = $clog2(MAX_ARB_PORTS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PASS  = 2'd1,
        FLUSH = 2'd2
    } arb_state_t;

endpackage

// File: rtl/vita49_stream_arb_rr_pick.sv
// Circular priority encoder: first set bit of req, searching from last_grant+1.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
//
// Ports:
//   req        request vector, one bit per requester
//   last_grant index of the previous winner; it has the lowest priority
//   grant_idx  winning index (0 when nothing requests)
//   grant_vld  high when any request is set
module rr_pick #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_vld
);

    int idx;

    // Walk from the farthest candidate back to the nearest so the nearest
    // requester after last_grant is the final (winning) assignment.
    always_comb begin
        grant_idx = '0;
        grant_vld = |req;
        idx       = 0;
        for (int i = N; i >= 1; i--) begin
            idx = int'(last_grant) + i;
            if (idx >= N) begin
                idx = idx - N;
            end
            if (req[idx]) begin
                grant_idx = IDX_W'(idx);
            end
        end
    end

endmodule

// File: rtl/vita49_stream_arb.sv
// Packet-granular round-robin merge of NUM_PORTS AXIS packet sources into one stream.
// Latency: one IDLE arbitration cycle per packet; data path is a zero-latency mux.
// Backpressure: M_AXIS_TREADY passes straight to the granted port; others see TREADY=0.
//
// Ports:
//   AXIS_ACLK / AXIS_ARESETN     stream clock, async active-low reset
//   S_AXIS_*                     NUM_PORTS packed source streams (port p at [32p+31:32p])
//   M_AXIS_*                     merged stream to the unpack engine
//   port_en                      per-port request enable
//   grant_id / busy              current or last grant, high while PASS or FLUSH
//   pkt_cnt / timeout_cnt        per-port completed packets, watchdog forced closes
module vita49_stream_arb
    import vita49_pkg::*;
#(
    parameter int NUM_PORTS      = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      AXIS_ACLK,
    input  logic                      AXIS_ARESETN,
    input  logic [32*NUM_PORTS-1:0]   S_AXIS_TDATA,
    input  logic [NUM_PORTS-1:0]      S_AXIS_TVALID,
    input  logic [NUM_PORTS-1:0]      S_AXIS_TLAST,
    output logic [NUM_PORTS-1:0]      S_AXIS_TREADY,
    output logic [31:0]               M_AXIS_TDATA,
    output logic                      M_AXIS_TVALID,
    output logic                      M_AXIS_TLAST,
    input  logic                      M_AXIS_TREADY,
    input  logic [NUM_PORTS-1:0]      port_en,
    output logic [GRANT_ID_W-1:0]     grant_id,
    output logic                      busy,
    output logic [32*NUM_PORTS-1:0]   pkt_cnt,
    output logic [31:0]               timeout_cnt
);

    localparam int GW    = $clog2(NUM_PORTS);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    arb_state_t                   state_q, state_d;
    logic [GW-1:0]                grant_q;
    logic [GW-1:0]                last_q;
    logic [31:0]                  idle_ctr_q;
    logic [NUM_PORTS-1:0][31:0]   pkt_cnt_q;
    logic [31:0]                  timeout_cnt_q;

    logic [NUM_PORTS-1:0][31:0]   s_dat;
    logic [NUM_PORTS-1:0]         req;
    logic [GW-1:0]                pick_idx;
    logic                         pick_vld;
    logic                         g_vld;
    logic                         g_last;
    logic                         pass_hs;
    logic                         idle_tick;
    logic [31:0]                  idle_inc;
    logic                         wd_fire;

    assign s_dat = S_AXIS_TDATA;
    assign req   = S_AXIS_TVALID & port_en;

    rr_pick #(
        .N     (NUM_PORTS),
        .IDX_W (GW)
    ) u_pick (
        .req        (req),
        .last_grant (last_q),
        .grant_idx  (pick_idx),
        .grant_vld  (pick_vld)
    );

    assign g_vld     = S_AXIS_TVALID[grant_q];
    assign g_last    = S_AXIS_TLAST[grant_q];
    assign pass_hs   = (state_q == PASS) && g_vld && M_AXIS_TREADY;
    assign idle_tick = (state_q == PASS) && !g_vld;
    assign idle_inc  = idle_ctr_q + 32'd1;
    // Fire on the cycle the counter reaches the limit, so FLUSH is presented
    // immediately after the TIMEOUT_CYCLES-th idle cycle.
    assign wd_fire   = WD_EN && idle_tick && (idle_inc == 32'(TIMEOUT_CYCLES));

    assign grant_id    = GRANT_ID_W'(grant_q);
    assign busy        = (state_q != IDLE);
    assign pkt_cnt     = pkt_cnt_q;
    assign timeout_cnt = timeout_cnt_q;

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        M_AXIS_TDATA  = '0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TLAST  = 1'b0;
        S_AXIS_TREADY = '0;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    state_d = PASS;
                end
            end
            PASS: begin
                M_AXIS_TDATA           = s_dat[grant_q];
                M_AXIS_TVALID          = g_vld;
                M_AXIS_TLAST           = g_last;
                S_AXIS_TREADY[grant_q] = M_AXIS_TREADY;
                // A handshake clears the idle count, so TLAST and expiry never coincide.
                if (pass_hs && g_last) begin
                    state_d = IDLE;
                end else if (wd_fire) begin
                    state_d = FLUSH;
                end
            end
            FLUSH: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TLAST  = 1'b1;
                if (M_AXIS_TREADY) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
        if (!AXIS_ARESETN) begin
            grant_q       <= '0;
            last_q        <= GW'(NUM_PORTS - 1);
            idle_ctr_q    <= '0;
            pkt_cnt_q     <= '0;
            timeout_cnt_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pick_vld) begin
                        grant_q    <= pick_idx;
                        idle_ctr_q <= '0;
                    end
                end
                PASS: begin
                    if (pass_hs) begin
                        idle_ctr_q <= '0;
                        if (g_last) begin
                            pkt_cnt_q[grant_q] <= pkt_cnt_q[grant_q] + 32'd1;
                            last_q             <= grant_q;
                        end
                    end else if (idle_tick && WD_EN) begin
                        idle_ctr_q <= idle_inc;
                    end
                end
                FLUSH: begin
                    if (M_AXIS_TREADY) begin
                        timeout_cnt_q <= timeout_cnt_q + 32'd1;
                        last_q        <= grant_q;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vita49_stream_arb.sv
// Directed bench for vita49_stream_arb: arbitration table plus multi-cycle sequences.
module tb_vita49_stream_arb;

    localparam int NP = 4;

    logic              aclk;
    logic              aresetn;
    logic [32*NP-1:0]  s_tdata;
    logic [NP-1:0]     s_tvalid;
    logic [NP-1:0]     s_tlast;
    logic [NP-1:0]     s_tready;
    logic [31:0]       m_tdata;
    logic              m_tvalid;
    logic              m_tlast;
    logic              m_tready;
    logic [NP-1:0]     port_en;
    logic [2:0]        grant_id;
    logic              busy;
    logic [32*NP-1:0]  pkt_cnt;
    logic [31:0]       timeout_cnt;

    vita49_stream_arb #(
        .NUM_PORTS      (NP),
        .TIMEOUT_CYCLES (8)
    ) dut (
        .AXIS_ACLK     (aclk),
        .AXIS_ARESETN  (aresetn),
        .S_AXIS_TDATA  (s_tdata),
        .S_AXIS_TVALID (s_tvalid),
        .S_AXIS_TLAST  (s_tlast),
        .S_AXIS_TREADY (s_tready),
        .M_AXIS_TDATA  (m_tdata),
        .M_AXIS_TVALID (m_tvalid),
        .M_AXIS_TLAST  (m_tlast),
        .M_AXIS_TREADY (m_tready),
        .port_en       (port_en),
        .grant_id      (grant_id),
        .busy          (busy),
        .pkt_cnt       (pkt_cnt),
        .timeout_cnt   (timeout_cnt)
    );

    initial aclk = 1'b0;
    always #5 aclk = ~aclk;

    int errors = 0;
    int checks = 0;

    // Source model: per-port word memory {last, data}; lim stalls a port after N words.
    logic [32:0] mem [NP][64];
    int          wr  [NP];
    int          rd  [NP];
    int          lim [NP];
    bit          rand_rdy;
    int          cyc;

    // Log of accepted output beats.
    logic [31:0] o_dat  [128];
    logic        o_last [128];
    logic [2:0]  o_gid  [128];
    int          o_cyc  [128];
    int          n_out;

    bit          hold_chk;
    logic [31:0] hold_dat;

    typedef struct {
        logic [3:0] vld;
        logic [3:0] en;
        logic [2:0] g;
        logic       bsy;
    } vec_t;
    vec_t tbl [13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] pc(input int p);
        return pkt_cnt[32*p +: 32];
    endfunction

    task automatic push_pkt(input int p, input int n, input logic [31:0] base);
        for (int w = 0; w < n; w++) begin
            mem[p][wr[p]] = {(w == n - 1), base + 32'(w)};
            wr[p]++;
        end
    endtask

    task automatic drive_srcs();
        for (int p = 0; p < NP; p++) begin
            if (rd[p] < wr[p] && rd[p] < lim[p]) begin
                s_tvalid[p]          = 1'b1;
                s_tdata[32*p +: 32]  = mem[p][rd[p]][31:0];
                s_tlast[p]           = mem[p][rd[p]][32];
            end else begin
                s_tvalid[p]          = 1'b0;
                s_tdata[32*p +: 32]  = '0;
                s_tlast[p]           = 1'b0;
            end
        end
    endtask

    function automatic bit drained();
        for (int p = 0; p < NP; p++) begin
            if (rd[p] < wr[p] && rd[p] < lim[p]) return 1'b0;
        end
        return 1'b1;
    endfunction

    task automatic do_reset();
        aresetn  = 1'b0;
        s_tvalid = '0;
        s_tdata  = '0;
        s_tlast  = '0;
        m_tready = 1'b0;
        port_en  = 4'hF;
        rand_rdy = 1'b0;
        hold_chk = 1'b0;
        n_out    = 0;
        cyc      = 0;
        for (int p = 0; p < NP; p++) begin
            wr[p] = 0; rd[p] = 0; lim[p] = 64;
        end
        for (int i = 0; i < 128; i++) begin
            o_dat[i] = '0; o_last[i] = 1'b0; o_gid[i] = '0; o_cyc[i] = 0;
        end
        @(posedge aclk);
        @(posedge aclk);
        #1;
        aresetn = 1'b1;
    endtask

    task automatic start();
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_srcs();
    endtask

    // One clock: sample and log at the falling edge, then drive the next inputs.
    task automatic cycle();
        @(negedge aclk);
        if (hold_chk) begin
            chk("stable_vld", {31'd0, m_tvalid}, 32'd1);
            chk("stable_dat", m_tdata, hold_dat);
        end
        hold_chk = m_tvalid && !m_tready;
        hold_dat = m_tdata;
        if (m_tvalid && m_tready && n_out < 128) begin
            o_dat[n_out]  = m_tdata;
            o_last[n_out] = m_tlast;
            o_gid[n_out]  = grant_id;
            o_cyc[n_out]  = cyc;
            n_out++;
        end
        for (int p = 0; p < NP; p++) begin
            if (s_tvalid[p] && s_tready[p]) rd[p]++;
        end
        @(posedge aclk);
        #1;
        cyc++;
        m_tready = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
        drive_srcs();
    endtask

    task automatic run_done(input int budget, input string name);
        int k;
        k = 0;
        while (k < budget) begin
            cycle();
            k++;
            if (drained() && !busy && !m_tvalid) break;
        end
        chk(name, (k < budget) ? 32'd1 : 32'd0, 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        // Reset release with idle inputs.
        do_reset();
        for (int k = 0; k < 10; k++) begin
            @(negedge aclk);
            chk($sformatf("rst_idle%0d", k),
                {20'd0, busy, m_tvalid, m_tlast, s_tready, grant_id,
                 |m_tdata, |pkt_cnt, |timeout_cnt}, 32'd0);
        end
        @(posedge aclk);
        #1;

        // Arbitration table: single-beat packets, expected winner hand-derived.
        tbl[0]  = '{4'hF, 4'hF, 3'd0, 1'b1};
        tbl[1]  = '{4'hF, 4'hF, 3'd1, 1'b1};
        tbl[2]  = '{4'h5, 4'hF, 3'd2, 1'b1};
        tbl[3]  = '{4'h5, 4'hF, 3'd0, 1'b1};
        tbl[4]  = '{4'h8, 4'h7, 3'd0, 1'b0};
        tbl[5]  = '{4'hA, 4'hF, 3'd1, 1'b1};
        tbl[6]  = '{4'hA, 4'hF, 3'd3, 1'b1};
        tbl[7]  = '{4'h1, 4'hF, 3'd0, 1'b1};
        tbl[8]  = '{4'hE, 4'h5, 3'd2, 1'b1};
        tbl[9]  = '{4'h3, 4'h2, 3'd1, 1'b1};
        tbl[10] = '{4'h9, 4'hF, 3'd3, 1'b1};
        tbl[11] = '{4'h9, 4'hF, 3'd0, 1'b1};
        tbl[12] = '{4'h0, 4'hF, 3'd0, 1'b0};
        for (int i = 0; i < 13; i++) begin
            s_tvalid = tbl[i].vld;
            port_en  = tbl[i].en;
            s_tlast  = 4'hF;
            m_tready = 1'b1;
            for (int p = 0; p < NP; p++) s_tdata[32*p +: 32] = 32'hC0DE_0000 + 32'(p);
            @(posedge aclk);
            #1;
            chk($sformatf("tbl%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].bsy});
            chk($sformatf("tbl%0d_gid", i), {29'd0, grant_id}, {29'd0, tbl[i].g});
            chk($sformatf("tbl%0d_mvld", i), {31'd0, m_tvalid}, {31'd0, tbl[i].bsy});
            chk($sformatf("tbl%0d_mdat", i), m_tdata,
                tbl[i].bsy ? 32'hC0DE_0000 + {29'd0, tbl[i].g} : 32'd0);
            chk($sformatf("tbl%0d_mlast", i), {31'd0, m_tlast}, {31'd0, tbl[i].bsy});
            @(posedge aclk);
            #1;
            s_tvalid = '0;
        end
        chk("tbl_pkt0", pc(0), 32'd4);
        chk("tbl_pkt1", pc(1), 32'd3);
        chk("tbl_pkt2", pc(2), 32'd2);
        chk("tbl_pkt3", pc(3), 32'd2);

        // Ports 0 and 2, 4-word packets: port 0, bubble, port 2.
        do_reset();
        push_pkt(0, 4, 32'h1000);
        push_pkt(2, 4, 32'h3000);
        start();
        run_done(60, "two_done");
        chk("two_nout", 32'(n_out), 32'd8);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("two_dat%0d", i), o_dat[i],
                (i < 4) ? 32'h1000 + 32'(i) : 32'h3000 + 32'(i - 4));
            chk($sformatf("two_last%0d", i), {31'd0, o_last[i]}, (i == 3 || i == 7) ? 32'd1 : 32'd0);
        end
        chk("two_first_lat", 32'(o_cyc[0]), 32'd1);
        chk("two_bubble", 32'(o_cyc[4] - o_cyc[3]), 32'd2);
        chk("two_gid2", {29'd0, o_gid[4]}, 32'd2);
        chk("two_pkt0", pc(0), 32'd1);
        chk("two_pkt1", pc(1), 32'd0);
        chk("two_pkt2", pc(2), 32'd1);

        // All four ports, three 3-word packets each: round-robin 0,1,2,3.
        do_reset();
        for (int n = 0; n < 3; n++) begin
            for (int p = 0; p < NP; p++) push_pkt(p, 3, 32'(p << 16) | 32'(n << 8));
        end
        start();
        run_done(200, "rr_done");
        chk("rr_nout", 32'(n_out), 32'd36);
        for (int i = 0; i < 36; i++) begin
            chk($sformatf("rr_dat%0d", i), o_dat[i],
                32'(((i / 3) % 4) << 16) | 32'(((i / 3) / 4) << 8) | 32'(i % 3));
            chk($sformatf("rr_gid%0d", i), {29'd0, o_gid[i]}, 32'((i / 3) % 4));
        end
        for (int p = 0; p < NP; p++) chk($sformatf("rr_pkt%0d", p), pc(p), 32'd3);

        // 16-word packet on port 1 with random downstream ready.
        do_reset();
        rand_rdy = 1'b1;
        push_pkt(1, 16, 32'h2000);
        start();
        run_done(400, "rnd_done");
        chk("rnd_nout", 32'(n_out), 32'd16);
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("rnd_dat%0d", i), o_dat[i], 32'h2000 + 32'(i));
        end
        chk("rnd_last", {31'd0, o_last[15]}, 32'd1);
        chk("rnd_pkt1", pc(1), 32'd1);

        // Watchdog: port 1 stalls after 2 of 4 words; port 2 waits behind it.
        do_reset();
        push_pkt(1, 4, 32'h6000);
        lim[1] = 2;
        push_pkt(2, 1, 32'h7000);
        start();
        run_done(60, "wd_done");
        chk("wd_nout", 32'(n_out), 32'd4);
        chk("wd_dat1", o_dat[1], 32'h6001);
        chk("wd_idle_gap", 32'(o_cyc[2] - o_cyc[1]), 32'd9);
        chk("wd_flush_dat", o_dat[2], 32'd0);
        chk("wd_flush_last", {31'd0, o_last[2]}, 32'd1);
        chk("wd_flush_gid", {29'd0, o_gid[2]}, 32'd1);
        chk("wd_next_gid", {29'd0, o_gid[3]}, 32'd2);
        chk("wd_next_dat", o_dat[3], 32'h7000);
        chk("wd_next_gap", 32'(o_cyc[3] - o_cyc[2]), 32'd2);
        chk("wd_tmo_cnt", timeout_cnt, 32'd1);
        chk("wd_pkt1", pc(1), 32'd0);
        chk("wd_pkt2", pc(2), 32'd1);

        // port_en[3] cleared mid-packet: packet completes, port 3 then ignored.
        do_reset();
        push_pkt(3, 4, 32'h4000);
        push_pkt(3, 2, 32'h4100);
        start();
        for (int k = 0; k < 20; k++) begin
            cycle();
            if (cyc == 2) begin
                port_en = 4'h7;
                push_pkt(0, 1, 32'h5000);
                drive_srcs();
            end
        end
        chk("en_nout", 32'(n_out), 32'd5);
        chk("en_gid3", {29'd0, o_gid[3]}, 32'd3);
        chk("en_dat3", o_dat[3], 32'h4003);
        chk("en_last3", {31'd0, o_last[3]}, 32'd1);
        chk("en_gid4", {29'd0, o_gid[4]}, 32'd0);
        chk("en_dat4", o_dat[4], 32'h5000);
        chk("en_pkt3", pc(3), 32'd1);
        chk("en_pkt0", pc(0), 32'd1);
        chk("en_busy", {31'd0, busy}, 32'd0);
        chk("en_tready", {28'd0, s_tready}, 32'd0);
        chk("en_rd3", 32'(rd[3]), 32'd4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
